action_requester: RTL

Initiator side of the home-action handshake. Converts button presses into eat/sleep requests and queues them in a small FIFO. Drives the level-held `doEat`/`doSleep` request lines into the home-action responder and sequences each request through issue, completion and release. Sits between the input/debounce logic and the home-action block in the pet top level.

---
 rtl/veridog_pkg.sv | 18 +
 rtl/action_fifo.sv | 56 +++++
 rtl/action_requester.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/veridog_pkg.sv
// Shared types for the pet top level: action codes, requester FSM states
// and the stat range.
package veridog_pkg;

  typedef enum logic {
    ACT_EAT   = 1'b0,
    ACT_SLEEP = 1'b1
  } act_code_t;

  typedef enum logic [1:0] {
    REQ_IDLE    = 2'd0,
    REQ_ISSUE   = 2'd1,
    REQ_RELEASE = 2'd2
  } req_state_t;

  localparam int STAT_MAX = 100;

endpackage

// File: rtl/action_fifo.sv
// Request FIFO of 1-bit action codes: up to two pushes and one pop per cycle.
// Push 0 is always written ahead of push 1.
module action_fifo
  import veridog_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push0,
  input  act_code_t     data0,
  input  logic          push1,
  input  act_code_t     data1,
  input  logic          pop,
  output act_code_t     head,
  output logic [CW-1:0] count,
  output logic          drop
);

  act_code_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] free;
  logic          acc0;
  logic          acc1;

  // Free slots are counted after the same-cycle pop.
  always_comb begin
    free = CW'(DEPTH) - count + CW'(pop);
    acc0 = push0 && (free != '0);
    acc1 = push1 && (free > CW'(acc0));
    drop = (push0 && !acc0) || (push1 && !acc1);
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr] <= data0;
    if (acc1) mem[wr_ptr + AW'(acc0)] <= data1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc0) + AW'(acc1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
    end
  end

endmodule

// File: rtl/action_requester.sv
// Initiator of the home-action handshake: button presses become queued
// eat/sleep requests. Optional auto-care requests: VERIDOG_AUTO_CARE_EN.
module action_requester
  import veridog_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int TIMEOUT     = 300_000_000,
  parameter  int AUTO_THRESH = 20,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int TW          = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          eatBtn,
  input  logic          sleepBtn,
  input  logic          done,
  input  logic [6:0]    hunger,
  input  logic [6:0]    sleepiness,
  output logic          doEat,
  output logic          doSleep,
  output logic          busy,
  output logic [CW-1:0] queueCount,
  output logic          dropped,
  output logic          timeout,
  output logic [1:0]    fsm_state
);

  // Handshake: doX is a level request held through ISSUE; the responder
  // raises done and holds it until doX falls; a new request is only issued
  // after done has been seen low again in RELEASE.
  req_state_t    state;
  req_state_t    state_next;
  act_code_t     code;
  act_code_t     head;
  act_code_t     data0;
  logic          eat_prev;
  logic          sleep_prev;
  logic          eat_press;
  logic          sleep_press;
  logic          push0;
  logic          push1;
  logic          pop;
  logic          drop;
  logic          tmo_hit;
  logic [TW-1:0] tcnt;

  always_comb begin
    eat_press   = eatBtn & ~eat_prev;
    sleep_press = sleepBtn & ~sleep_prev;
    push0       = eat_press | sleep_press;
    data0       = eat_press ? ACT_EAT : ACT_SLEEP;
    push1       = eat_press & sleep_press;
`ifdef VERIDOG_AUTO_CARE_EN
    // Empty queue in IDLE means no request is outstanding, so at most one
    // auto request is made per IDLE visit.
    if (state == REQ_IDLE && queueCount == '0 && !push0) begin
      if (hunger < 7'(AUTO_THRESH)) begin
        push0 = 1'b1;
        data0 = ACT_EAT;
      end else if (sleepiness < 7'(AUTO_THRESH)) begin
        push0 = 1'b1;
        data0 = ACT_SLEEP;
      end
    end
`endif
  end

`ifndef VERIDOG_AUTO_CARE_EN
  logic unused_stats;
  assign unused_stats = (^{hunger, sleepiness}) ^ (AUTO_THRESH > STAT_MAX);
`endif

  action_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push0  (push0),
    .data0  (data0),
    .push1  (push1),
    .data1  (ACT_SLEEP),
    .pop    (pop),
    .head   (head),
    .count  (queueCount),
    .drop   (drop)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      REQ_IDLE: begin
        if (queueCount != '0) begin
          pop        = 1'b1;
          state_next = REQ_ISSUE;
        end
      end
      REQ_ISSUE: begin
        if (done) begin
          state_next = REQ_RELEASE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          state_next = REQ_RELEASE;
        end
      end
      REQ_RELEASE: begin
        if (!done) state_next = REQ_IDLE;
      end
      default: state_next = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= REQ_IDLE;
      code       <= ACT_EAT;
      tcnt       <= '0;
      eat_prev   <= 1'b0;
      sleep_prev <= 1'b0;
      doEat      <= 1'b0;
      doSleep    <= 1'b0;
      dropped    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      eat_prev   <= eatBtn;
      sleep_prev <= sleepBtn;
      dropped    <= drop;
      timeout    <= tmo_hit;
      if (pop) begin
        code <= head;
        tcnt <= '0;
      end else if (state == REQ_ISSUE && tcnt != '1) begin
        tcnt <= tcnt + TW'(1);
      end
      // Lags the state by one cycle: high 2 cycles after a press, low one
      // cycle after done is sampled.
      doEat   <= (state == REQ_ISSUE) && (code == ACT_EAT);
      doSleep <= (state == REQ_ISSUE) && (code == ACT_SLEEP);
    end
  end

  assign busy      = (state != REQ_IDLE);
  assign fsm_state = state;

endmodule
